load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the word-wide data memory port (line/write_data/write/data). Accepts one RV32I
//  load/store request at a time from the core, converts byte/halfword/word accesses into line
//  reads and writes, and returns sign/zero-extended load data. Sub-word stores use read-modify-write.
// PARAMETERS
//  ADDR_LINE_W  12  width of mem_line; line index = req_addr[ADDR_LINE_W+1:2]
//  XLEN         32  data width of core and memory
// PORTS
//  clk             in   1            rising-edge clock
//  reset           in   1            synchronous, active-high
//  req_valid       in   1            core presents a request
//  req_ready       out  1            unit idle, request accepted when req_valid&&req_ready
//  req_write       in   1            1=store, 0=load
//  req_funct3      in   3            RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr        in   XLEN         byte address
//  req_wdata       in   XLEN         store data (low bits used for B/H)
//  resp_valid      out  1            one-cycle pulse: access complete
//  resp_rdata      out  XLEN         extended load data; 0 for stores
//  resp_fault      out  1            misaligned access (only driven with MISALIGN_TRAP_EN, else 0)
//  mem_line        out  ADDR_LINE_W  memory line index
//  mem_write       out  1            memory write enable
//  mem_write_data  out  XLEN         memory write word
//  mem_data        in   XLEN         memory read word for mem_line
// BEHAVIOUR
//  Reset (sampled at edge): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0,
//   mem_write=0, mem_line=0, mem_write_data=0. Reset mid-operation aborts; no write issued after it.
//  States: IDLE, READ, WRITE, RESP. req_ready=1 only in IDLE. mem_write=1 only in WRITE.
//  On accept: latch write, funct3, addr, wdata; mem_line<=addr[ADDR_LINE_W+1:2] held until RESP.
//  Load:   IDLE->READ->RESP. In READ, mem_data sampled at edge, lane selected by addr[1:0],
//          extended (B/H sign, BU/HU zero) into resp_rdata. resp_valid 2 cycles after accept.
//  SW:     IDLE->WRITE->RESP; mem_write_data=wdata. resp_valid 2 cycles after accept.
//  SB/SH:  IDLE->READ->WRITE->RESP; READ captures mem_data, WRITE drives word with addressed lane(s)
//          replaced, other bytes unchanged. resp_valid 3 cycles after accept.
//  RESP:   resp_valid=1 one cycle, ->IDLE; new request accepted earliest the cycle after RESP.
//  resp_rdata holds last load value until next load completes; stores drive it 0 in RESP.
//  Unlisted funct3 (011,110,111) treated as word access. Address bits above line range ignored.
//  H lanes: addr[1]=0 bytes[15:0], 1 bytes[31:16]. Without macro, misaligned H/W ignore low bits
//   (H uses addr[1], W uses aligned word).
//  req_* inputs ignored outside IDLE; req_valid low in IDLE keeps state IDLE.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 goes IDLE->RESP directly,
//   resp_fault=1 with resp_valid, no memory write, resp_rdata=0; latency 1 cycle after accept.
//  Undefined: resp_fault tied 0; alignment truncated as above.
// STRUCTURE
//  Shared header lsu_defs.vh: funct3 localparams (F3_B,F3_H,F3_W,F3_BU,F3_HU), state encodings.
//  Sub-module lsu_align (combinational): load extract/extend and store lane merge from
//   funct3, addr[1:0], word, wdata. FSM and registers stay in load_store_unit.
// TESTING  (bench instantiates the data memory module as responder)
//  SW addr 0x4 data 0xDEADBEEF, then LW 0x4 -> mem line 1 = 0xDEADBEEF, resp_rdata 0xDEADBEEF 2 cyc.
//  SB 0x80 to addr 0x5 over that word, LW 0x4 -> 0xDEAD80EF; SB takes 3 cycles, other bytes intact.
//  LB 0x5 -> 0xFFFFFF80; LBU 0x5 -> 0x00000080; LH 0x6 -> 0xFFFFDEAD; LHU 0x6 -> 0x0000DEAD.
//  Back-to-back req_valid held high -> req_ready low in READ/WRITE/RESP, exactly one resp per accept.
//  reset asserted during SB in READ -> next cycle IDLE, mem_write never 1, memory word unchanged.
//  MISALIGN_TRAP_EN: LW 0x6 -> resp_fault=1, resp_rdata=0 1 cyc; without macro returns word at 0x4.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// load_store_unit_pkg: funct3 codes, FSM state encoding and access-size decode shared by the LSU files. Rev 1.0
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Reserved funct3 codes fall through to a full-word access.
  function automatic size_t access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      F3_W:        return SZ_WORD;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// load_store_unit_if: core request/response channel plus the word-wide data memory port. Rev 1.0
interface load_store_unit_if #(
  parameter int ADDR_LINE_W = 12,
  parameter int XLEN        = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [2:0]             req_funct3;
  logic [XLEN-1:0]        req_addr;
  logic [XLEN-1:0]        req_wdata;
  logic                   resp_valid;
  logic [XLEN-1:0]        resp_rdata;
  logic                   resp_fault;
  logic [ADDR_LINE_W-1:0] mem_line;
  logic                   mem_write;
  logic [XLEN-1:0]        mem_write_data;
  logic [XLEN-1:0]        mem_data;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_line, mem_write, mem_write_data
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_line, mem_write, mem_write_data
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// lsu_align: combinational lane extract/extend for loads and lane merge for sub-word stores. Rev 1.0
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  size_t       size;

  always_comb begin
    size   = access_size(funct3_i);
    lane_b = word_i[7:0];
    case (addr_lo_i)
      2'd0: lane_b = word_i[7:0];
      2'd1: lane_b = word_i[15:8];
      2'd2: lane_b = word_i[23:16];
      2'd3: lane_b = word_i[31:24];
      default: lane_b = word_i[7:0];
    endcase
    lane_h = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    // funct3[2] marks the unsigned (BU/HU) variants.
    load_data_o  = word_i;
    store_word_o = wdata_i;
    case (size)
      SZ_BYTE: begin
        load_data_o  = funct3_i[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
        store_word_o = word_i;
        case (addr_lo_i)
          2'd0: store_word_o[7:0]   = wdata_i[7:0];
          2'd1: store_word_o[15:8]  = wdata_i[7:0];
          2'd2: store_word_o[23:16] = wdata_i[7:0];
          2'd3: store_word_o[31:24] = wdata_i[7:0];
          default: store_word_o = word_i;
        endcase
      end
      SZ_HALF: begin
        load_data_o  = funct3_i[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
        store_word_o = addr_lo_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                    : {word_i[31:16], wdata_i[15:0]};
      end
      default: begin
        load_data_o  = word_i;
        store_word_o = wdata_i;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: one-at-a-time RV32I load/store initiator with read-modify-write sub-word stores. Rev 1.0
// Define MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of truncating the address.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_LINE_W = 12,
  parameter int XLEN        = 32
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.master bus
);

  state_t                 state_q, state_d;
  logic                   write_q;
  logic [2:0]             funct3_q;
  logic [1:0]             addr_lo_q;
  logic [XLEN-1:0]        wdata_q;
  logic [ADDR_LINE_W-1:0] line_q;
  logic [XLEN-1:0]        rdata_q;
  logic [XLEN-1:0]        mem_wdata_q;
  logic                   fault_q;
  logic                   accept;
  logic                   misalign;
  logic [XLEN-1:0]        load_data;
  logic [XLEN-1:0]        merge_data;
  logic                   unused_addr;

  assign accept      = (state_q == S_IDLE) && bus.req_valid;
  assign unused_addr = ^bus.req_addr[XLEN-1:ADDR_LINE_W+2];

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (access_size(bus.req_funct3))
      SZ_HALF: misalign = bus.req_addr[0];
      SZ_WORD: misalign = |bus.req_addr[1:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  lsu_align u_align (
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_lo_q),
    .word_i       (bus.mem_data),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (merge_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Loads and sub-word stores read first; only full-word stores skip straight to WRITE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (misalign)
            state_d = S_RESP;
          else if (!bus.req_write || access_size(bus.req_funct3) != SZ_WORD)
            state_d = S_READ;
          else
            state_d = S_WRITE;
        end
      end
      S_READ:  state_d = write_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q     <= 1'b0;
      funct3_q    <= F3_W;
      addr_lo_q   <= 2'd0;
      wdata_q     <= '0;
      line_q      <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      if (accept) begin
        write_q   <= bus.req_write;
        funct3_q  <= bus.req_funct3;
        addr_lo_q <= bus.req_addr[1:0];
        wdata_q   <= bus.req_wdata;
        line_q    <= bus.req_addr[ADDR_LINE_W+1:2];
        fault_q   <= misalign;
        if (bus.req_write) mem_wdata_q <= bus.req_wdata;
      end
      if (state_q == S_READ) begin
        if (write_q) mem_wdata_q <= merge_data;
        else         rdata_q     <= load_data;
      end
    end
  end

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.resp_valid     = (state_q == S_RESP);
  assign bus.mem_write      = (state_q == S_WRITE);
  assign bus.mem_line       = line_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.resp_rdata     = ((state_q == S_RESP) && (write_q || fault_q)) ? '0 : rdata_q;
`ifdef MISALIGN_TRAP_EN
  assign bus.resp_fault     = (state_q == S_RESP) && fault_q;
`else
  assign bus.resp_fault     = 1'b0;
`endif

endmodule
`default_nettype wire
